qam4_demapper: RTL and testbench

QAM4_DEMAPPER -- requirements
Module: qam4_demapper

---
 rtl/qam4_demapper.sv | 165 ++++++++++++++++
 tb/tb_qam4_demapper.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam4_demapper.sv
// QPSK (4-QAM) hard-decision demapper: packs four 2-bit symbols per byte with frame tracking.
// Optional frame error accumulator enabled by the QAM4_DEMAP_ERR_EN macro.
module qam4_demapper #(
   parameter int WORD_SIZE = 16,
   parameter int FRAME_LEN = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic signed [WORD_SIZE-1:0] i_re,
   input  logic signed [WORD_SIZE-1:0] i_im,
   input  logic                        i_sof,
   output logic [7:0]                  o_byte,
   output logic                        o_byte_valid,
   input  logic                        i_byte_ready,
   output logic                        o_frame_done
`ifdef QAM4_DEMAP_ERR_EN
   ,
   output logic [WORD_SIZE+5:0]        o_err_acc
`endif
);

   localparam int              FCW        = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
   localparam logic [FCW-1:0]  FRAME_LAST = FCW'(FRAME_LEN - 1);
   localparam logic [FCW-1:0]  FRAME_ONE  = {{(FCW-1){1'b0}}, 1'b1};

   // HOLD means a byte is pending in o_byte
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } state_t;

   state_t         state;
   state_t         state_next;
   logic           accept;
   logic [1:0]     sym;
   logic [1:0]     sym_idx;
   logic [FCW-1:0] frame_idx;
   logic           complete;
   logic           frame_end;
   logic [1:0]     sym_cnt;
   logic [FCW-1:0] frame_cnt;
   logic [5:0]     pack;

   assign o_ready = ~(o_byte_valid & ~i_byte_ready);

   // Sign-bit decision and position of the incoming symbol (sof restarts the frame)
   always_comb begin
      accept    = i_valid & o_ready;
      sym       = {i_re[WORD_SIZE-1], i_re[WORD_SIZE-1] ^ i_im[WORD_SIZE-1]};
      sym_idx   = i_sof ? 2'd0 : sym_cnt;
      frame_idx = i_sof ? {FCW{1'b0}} : frame_cnt;
      complete  = accept & (sym_idx == 2'd3);
      frame_end = complete & (frame_idx == FRAME_LAST);
   end

   // Next-state logic of the packing FSM
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (complete)    state_next = HOLD;
            else if (accept) state_next = COLLECT;
            else             state_next = IDLE;
         end
         COLLECT: begin
            if (complete) state_next = HOLD;
            else          state_next = COLLECT;
         end
         HOLD: begin
            if (complete)          state_next = HOLD;
            else if (accept)       state_next = COLLECT;
            else if (i_byte_ready) state_next = IDLE;
            else                   state_next = HOLD;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register and registered handshake outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= IDLE;
         o_byte_valid <= 1'b0;
         o_frame_done <= 1'b0;
      end else begin
         state        <= state_next;
         o_byte_valid <= (state_next == HOLD);
         o_frame_done <= frame_end;
      end
   end

   // Symbol/frame counters, packing register and output byte
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sym_cnt   <= 2'd0;
         frame_cnt <= {FCW{1'b0}};
         pack      <= 6'd0;
         o_byte    <= 8'd0;
      end else if (accept) begin
         sym_cnt   <= sym_idx + 2'd1;
         frame_cnt <= (frame_idx == FRAME_LAST) ? {FCW{1'b0}} : frame_idx + FRAME_ONE;
         case (sym_idx)
            2'd0:    pack      <= {4'd0, sym};
            2'd1:    pack[3:2] <= sym;
            2'd2:    pack[5:4] <= sym;
            default: begin
               pack   <= 6'd0;
               o_byte <= {sym, pack};
            end
         endcase
      end else begin
         pack <= pack;
      end
   end

`ifdef QAM4_DEMAP_ERR_EN
   localparam logic [WORD_SIZE-2:0] REF_I = (WORD_SIZE-1)'(10'd362);
   localparam logic [WORD_SIZE-2:0] REF_Q = (WORD_SIZE-1)'(8'd201);

   // Magnitude; the most negative value saturates to the largest positive one
   function automatic logic [WORD_SIZE-2:0] mag_sat(input logic [WORD_SIZE-1:0] v);
      logic [WORD_SIZE-1:0] n;
      n = v[WORD_SIZE-1] ? (~v + {{(WORD_SIZE-1){1'b0}}, 1'b1}) : v;
      if (n[WORD_SIZE-1]) return {(WORD_SIZE-1){1'b1}};
      else                return n[WORD_SIZE-2:0];
   endfunction

   function automatic logic [WORD_SIZE-2:0] dist(input logic [WORD_SIZE-2:0] a,
                                                 input logic [WORD_SIZE-2:0] b);
      if (a >= b) return a - b;
      else        return b - a;
   endfunction

   logic [WORD_SIZE-1:0] sym_err;
   logic [WORD_SIZE+5:0] acc;
   logic [WORD_SIZE+5:0] acc_base;
   logic [WORD_SIZE+6:0] acc_sum;
   logic [WORD_SIZE+5:0] acc_next;

   // Per-symbol distance to the ideal point, summed with saturation
   always_comb begin
      sym_err  = {1'b0, dist(mag_sat(i_re), REF_I)} + {1'b0, dist(mag_sat(i_im), REF_Q)};
      acc_base = (frame_idx == {FCW{1'b0}}) ? {(WORD_SIZE+6){1'b0}} : acc;
      acc_sum  = {1'b0, acc_base} + {7'd0, sym_err};
      acc_next = acc_sum[WORD_SIZE+6] ? {(WORD_SIZE+6){1'b1}} : acc_sum[WORD_SIZE+5:0];
   end

   // Running frame error and its snapshot published with o_frame_done
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         acc       <= {(WORD_SIZE+6){1'b0}};
         o_err_acc <= {(WORD_SIZE+6){1'b0}};
      end else begin
         if (accept)    acc       <= acc_next;
         else           acc       <= acc;
         if (frame_end) o_err_acc <= acc_next;
         else           o_err_acc <= o_err_acc;
      end
   end
`endif

endmodule

// File: tb/tb_qam4_demapper.sv
// Scoreboard bench for qam4_demapper: randomized samples against a frame-level reference model.
module tb_qam4_demapper;
   localparam int W  = 16;
   localparam int FL = 16;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                valid = 1'b0;
   logic                sof = 1'b0;
   logic                byte_ready = 1'b1;
   logic signed [W-1:0] re = '0;
   logic signed [W-1:0] im = '0;
   logic                o_ready;
   logic [7:0]          o_byte;
   logic                o_byte_valid;
   logic                o_frame_done;
`ifdef QAM4_DEMAP_ERR_EN
   logic [W+5:0]        o_err_acc;
`endif

   qam4_demapper #(.WORD_SIZE(W), .FRAME_LEN(FL)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready),
      .i_re(re), .i_im(im), .i_sof(sof),
      .o_byte(o_byte), .o_byte_valid(o_byte_valid), .i_byte_ready(byte_ready),
      .o_frame_done(o_frame_done)
`ifdef QAM4_DEMAP_ERR_EN
      , .o_err_acc(o_err_acc)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int bp_mode = 0;
   int fd_count = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s: %s", name, what);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0] b;
      bit         fd;
      longint     err;
   } exp_t;

   exp_t       q[$];
   int         m_pos = 0;
   logic [7:0] m_part = 8'd0;
   longint     m_ferr = 0;

   function automatic int magsat(input int v);
      if (v == -(1 << (W-1))) return (1 << (W-1)) - 1;
      return (v < 0) ? -v : v;
   endfunction

   function automatic int absd(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic model_accept(input int r, input int i, input bit s);
      int   slot;
      int   sy;
      exp_t e;
      if (s) m_pos = 0;
      if (r >= 0) sy = (i >= 0) ? 0 : 1;
      else        sy = (i < 0) ? 2 : 3;
      if (m_pos == 0) m_ferr = 0;
      m_ferr += absd(magsat(r) - 362) + absd(magsat(i) - 201);
      slot = m_pos % 4;
      if (slot == 0) m_part = 8'd0;
      m_part |= 8'(sy << (2 * slot));
      if (slot == 3) begin
         e.b   = m_part;
         e.fd  = (m_pos == FL - 1);
         e.err = m_ferr;
         q.push_back(e);
      end
      m_pos = (m_pos + 1) % FL;
   endtask

   // ---------------- drivers ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            0:       byte_ready = 1'b1;
            1:       byte_ready = ($urandom_range(0, 3) != 0);
            default: byte_ready = 1'b0;
         endcase
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input int r, input int i, input bit s);
      bit acc = 1'b0;
      re    = W'(r);
      im    = W'(i);
      sof   = s;
      valid = 1'b1;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         acc = o_ready;
         @(posedge clk);
         #1;
      end
      valid = 1'b0;
      sof   = 1'b0;
      if (acc) model_accept(r, i, s);
      else     fail("accept_timeout", "sample not accepted within 200 cycles");
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 500 && q.size() > 0; n++) @(posedge clk);
      #1;
      check("drain_queue_empty", q.size(), 0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [7:0] prev_byte = 8'd0;
   bit         prev_stall = 1'b0;
   bit         seen_fd = 1'b0;
   exp_t       h;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
         seen_fd    = 1'b0;
      end else begin
         check("ready_rule", o_ready, !(o_byte_valid && !byte_ready));
         if (prev_stall) check("byte_stable", o_byte, prev_byte);
         if (o_frame_done) begin
            fd_count++;
            if (q.size() == 0 || !o_byte_valid) fail("frame_done_spurious", "pulse without a pending byte");
            else begin
               check("frame_done_pos", q[0].fd, 1);
`ifdef QAM4_DEMAP_ERR_EN
               check("err_acc", o_err_acc, q[0].err);
`endif
               seen_fd = 1'b1;
            end
         end
         if (o_byte_valid && byte_ready) begin
            if (q.size() == 0) fail("unexpected_byte", $sformatf("got byte %02h, none expected", o_byte));
            else begin
               h = q.pop_front();
               check("byte", o_byte, h.b);
               check("frame_done_seen", seen_fd, h.fd);
               seen_fd = 1'b0;
            end
         end
         prev_stall = o_byte_valid && !byte_ready;
         prev_byte  = o_byte;
      end
   end

   // ---------------- stimulus ----------------
   int fd_before;
   logic [7:0] held;

   initial begin
      rst = 1'b1;
      #12;
      check("rst_byte_valid", o_byte_valid, 0);
      check("rst_byte", o_byte, 0);
      check("rst_frame_done", o_frame_done, 0);
      check("rst_ready", o_ready, 1);
`ifdef QAM4_DEMAP_ERR_EN
      check("rst_err_acc", o_err_acc, 0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);

      // Four quadrants -> E4, valid one cycle after the 4th accept
      send(362, 201, 1'b1); send(362, -201, 1'b0); send(-362, -201, 1'b0); send(-362, 201, 1'b0);
      check("lat_valid", o_byte_valid, 1);
      check("lat_byte", o_byte, 8'hE4);
      idle(2);

      // Zero treated as positive
      send(0, 0, 1'b1); send(0, -1, 1'b0); send(-1, -1, 1'b0); send(-1, 0, 1'b0);
      check("zero_byte", o_byte, 8'hE4);
      idle(2);

      // Full ideal frame: exactly one frame_done, zero error
      fd_before = fd_count;
      for (int k = 0; k < FL; k++)
         send($urandom_range(0, 1) ? 362 : -362, $urandom_range(0, 1) ? 201 : -201, k == 0);
      idle(2);
      check("ideal_frame_done_count", fd_count - fd_before, 1);
`ifdef QAM4_DEMAP_ERR_EN
      check("ideal_err_acc", o_err_acc, 0);
`endif

      // Backpressure: byte held, no acceptance, then drain
      bp_mode = 2;
      idle(1);
      send(-362, 201, 1'b1); send(362, 201, 1'b0); send(362, -201, 1'b0); send(-362, -201, 1'b0);
      held  = o_byte;
      re    = W'(100);
      im    = W'(100);
      valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_ready_low", o_ready, 0);
         check("stall_byte_held", o_byte, held);
      end
      @(posedge clk);
      #1;
      valid   = 1'b0;
      bp_mode = 0;
      @(posedge clk);
      #2;
      @(posedge clk);
      @(negedge clk);
      check("drained_valid", o_byte_valid, 0);
      check("drained_ready", o_ready, 1);
      @(posedge clk);
      #1;

      // Partial byte discarded by reset
      send(-362, -201, 1'b0); send(-362, 201, 1'b0);
      wait_drain();
      #2;
      rst = 1'b1;
      m_pos = 0;
      #3;
      check("midrst_byte_valid", o_byte_valid, 0);
      check("midrst_byte", o_byte, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);
      for (int k = 0; k < 4; k++) send(362, 201, 1'b0);
      check("after_rst_byte", o_byte, 8'h00);
      check("after_rst_valid", o_byte_valid, 1);
      idle(2);

      // Partial byte discarded by sof
      send(-362, -201, 1'b0); send(-362, 201, 1'b0);
      for (int k = 0; k < 4; k++) send(362, 201, k == 0);
      check("after_sof_byte", o_byte, 8'h00);
      idle(2);

      // Most negative samples saturate
      for (int k = 0; k < FL; k++) send(-32768, -32768, k == 0);
      check("sat_byte", o_byte, 8'hAA);
`ifdef QAM4_DEMAP_ERR_EN
      check("sat_err_acc", o_err_acc, 1039536);
`endif
      idle(2);

      // Randomized traffic with backpressure, gaps and occasional sof
      bp_mode = 1;
      for (int k = 0; k < 400; k++) begin
         int r;
         int i;
         if ($urandom_range(0, 5) == 0) begin
            r = $urandom_range(0, 1) ? -32768 : 32767;
            i = $urandom_range(0, 2) == 0 ? 0 : -32768;
         end else begin
            r = $urandom_range(0, 65535) - 32768;
            i = $urandom_range(0, 65535) - 32768;
         end
         send(r, i, $urandom_range(0, 19) == 0);
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      end
      bp_mode = 0;
      wait_drain();
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
